regfile_mp_sb: RTL and testbench
================================

Name: regfile_mp_sb

Overview:
Parametrised multi-port integer register file with a per-register busy scoreboard. It is the successor to the single-write, dual-read regfile in the core.
- Serves N combinational read ports and M write-back ports.
- Tracks registers with in-flight producers (loads, multi-cycle ops) so that issue logic can stall on read-after-write hazards.
- Sits between decode/issue (reads, scoreboard set) and the write-back stage (writes, scoreboard clear).

Parameters:
XLEN, 32, data width of each register.
NREGS, 32, number of architectural registers; power of two, at least 2.
NREAD, 2, number of read ports.
NWRITE, 2, number of write ports; port index NWRITE-1 has highest priority.
ZERO_REG, 1, when 1, register 0 is hardwired to zero and never busy.
AW, $clog2(NREGS), address width (derived; not overridden).

Ports:
clk  input  1  clock.
rst_n  input  1  synchronous active-low reset.
rd_addr  input  NREAD*AW  packed read addresses; port i occupies bits [i*AW +: AW].
rd_data  output  NREAD*XLEN  packed read data, combinational from rd_addr.
rd_busy  output  NREAD  busy bit of each addressed register, combinational.
wr_en  input  NWRITE  per-port write enable.
wr_addr  input  NWRITE*AW  packed write addresses.
wr_data  input  NWRITE*XLEN  packed write data.
sb_set_en  input  1  mark register sb_set_addr busy (producer issued).
sb_set_addr  input  AW  register to mark busy.
flush  input  1  clear all busy bits; register data is untouched.
busy_cnt  output  $clog2(NREGS+1)  registered count of busy registers.
busy_vec  output  NREGS  registered busy bits, bit k = register k.

Behaviour:
- The block is built for the simulation/FPGA flow (reset loops all registers).
- Reset (rst_n low at posedge clk):
  - all registers become 0;
  - busy_vec and busy_cnt become 0;
  - a reset takes precedence over any same-cycle write, set or flush.
- Reads:
  - purely combinational: rd_data[i] = reg[rd_addr[i]], rd_busy[i] = busy_vec[rd_addr[i]];
  - zero latency; no read enable.
- Writes:
  - at posedge, for each port j with wr_en[j]: reg[wr_addr[j]] <= wr_data[j].
  - Same address on two enabled ports in one cycle: the highest port index wins; the others are dropped without error.
  - Writes to register 0 are ignored when ZERO_REG=1.
- Scoreboard clear: any enabled write to register k clears busy_vec[k] at the same edge. A write to a non-busy register simply writes data.
- Scoreboard set: sb_set_en sets busy_vec[sb_set_addr] at posedge. It is ignored for register 0 when ZERO_REG=1.
- Set/clear precedence (per register, same cycle):
  - set and a write-clear on the same register: set wins (register stays busy, data is still written), because the new producer supersedes the retiring one;
  - flush clears all bits, but a same-cycle sb_set_en is still applied after the flush (the instruction issues into the post-flush stream);
  - flush and a write in the same cycle: the data is written and the register's busy bit is cleared.
- busy_cnt:
  - always equals popcount(busy_vec) at every cycle boundary;
  - implemented as a registered up/down counter: +1 when a set makes a 0 bit 1, -1 per write that clears a 1 bit not re-set;
  - after a flush it equals the 0 or 1 contributed by a same-cycle set.
- ZERO_REG=1: rd_data for address 0 is always 0 and rd_busy is always 0, regardless of any attempted write or set.
- ZERO_REG=0: register 0 behaves like any other register.
- No internal state machine beyond the busy bits and the counter; no backpressure.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined: reads are write-first.
  - If wr_en[j] is set and wr_addr[j] equals rd_addr[i] in the same cycle, rd_data[i] returns wr_data[j]; the highest enabled j wins.
  - rd_busy[i] then reflects the post-edge busy value: 0 unless sb_set targets the same register.
  - The zero-register rule still applies.
- Undefined: reads return pre-edge register contents and pre-edge busy bits; the new value becomes visible the cycle after the write.

Test Plan:
1. Reset with all read ports at addresses 0..NREAD-1 -> rd_data all 0, rd_busy 0, busy_cnt 0.
2. Write port 0: x5=0xDEADBEEF, then read x5 on port 1 next cycle -> 0xDEADBEEF. Write x0=0x1234 -> read x0 returns 0.
3. Both write ports target x7 (port 0 = 0x11, port 1 = 0x22) -> x7 = 0x22.
4. sb_set x3, then x4 -> busy_cnt 2, rd_busy for x3 = 1. Write x3 -> busy_cnt 1, x3 not busy. Same-cycle sb_set x4 plus write x4 -> x4 stays busy, data updated, busy_cnt still 1.
5. With x3, x4, x9 busy, assert flush together with sb_set x10 -> busy_vec has only bit 10 set, busy_cnt 1, register data unchanged.
6. Write x6=0xA5A5A5A5 while reading x6 in the same cycle -> rd_data is 0xA5A5A5A5 with REGFILE_BYPASS_EN defined, the old value without it. Additionally, rst_n low mid-sequence -> all state zeroed at that edge.

Source files
------------

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with a per-register busy scoreboard for RAW hazard stalls.
// Latency: reads are combinational; writes, scoreboard set/clear and busy_cnt update at posedge clk.
// Backpressure: none; every write, set and flush is accepted in the cycle it is presented.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset (clears data, busy bits and count)
//   rd_addr/rd_data/rd_busy   NREAD packed read ports, combinational data and busy bit
//   wr_en/wr_addr/wr_data     NWRITE packed write-back ports, highest port index wins a collision
//   sb_set_en/sb_set_addr     mark a register busy when its producer issues
//   flush                 clear every busy bit (register data untouched)
//   busy_cnt/busy_vec     registered busy count and busy bit vector
//
// Optional: define REGFILE_BYPASS_EN for write-first reads (same-cycle write data and
// post-edge busy bit forwarded to matching read ports).
module regfile_mp_sb #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NREAD    = 2,
  parameter int NWRITE   = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS),
  localparam int CW      = $clog2(NREGS + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREAD*AW-1:0]     rd_addr,
  output logic [NREAD*XLEN-1:0]   rd_data,
  output logic [NREAD-1:0]        rd_busy,
  input  logic [NWRITE-1:0]       wr_en,
  input  logic [NWRITE*AW-1:0]    wr_addr,
  input  logic [NWRITE*XLEN-1:0]  wr_data,
  input  logic                    sb_set_en,
  input  logic [AW-1:0]           sb_set_addr,
  input  logic                    flush,
  output logic [CW-1:0]           busy_cnt,
  output logic [NREGS-1:0]        busy_vec
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [NREGS-1:0] clr_vec, set_vec;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Register 0 is a constant when ZERO_REG is set: it swallows writes and sets.
  function automatic logic is_zero_reg(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Write path and scoreboard next state.
  always_comb begin
    regs_d  = regs_q;
    clr_vec = '0;
    set_vec = '0;
    // Ascending port order so the highest enabled port is the last assignment.
    for (int j = 0; j < NWRITE; j++) begin
      if (wr_en[j] && !is_zero_reg(wr_addr[j*AW +: AW])) begin
        regs_d[wr_addr[j*AW +: AW]]  = wr_data[j*XLEN +: XLEN];
        clr_vec[wr_addr[j*AW +: AW]] = 1'b1;
      end
    end
    if (sb_set_en && !is_zero_reg(sb_set_addr)) begin
      set_vec[sb_set_addr] = 1'b1;
    end
    // Set is applied after clear/flush: a newly issued producer supersedes a retiring one.
    if (flush) begin
      busy_d = set_vec;
    end else begin
      busy_d = (busy_q & ~clr_vec) | set_vec;
    end
  end

  // Up/down busy counter tracking popcount(busy_vec) without a per-cycle adder tree.
  always_comb begin
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d    = '0;
      cnt_d[0] = |set_vec;
    end else begin
      if (|(set_vec & ~busy_q)) begin
        cnt_d = cnt_d + CW'(1);
      end
      for (int k = 0; k < NREGS; k++) begin
        if (busy_q[k] && clr_vec[k] && !set_vec[k]) begin
          cnt_d = cnt_d - CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  // Combinational read ports.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NREAD; i++) begin
      rd_data[i*XLEN +: XLEN] = regs_q[rd_addr[i*AW +: AW]];
      rd_busy[i]              = busy_q[rd_addr[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
      // Write-first: forward same-cycle write data and the post-edge busy bit.
      for (int j = 0; j < NWRITE; j++) begin
        if (wr_en[j] && (wr_addr[j*AW +: AW] == rd_addr[i*AW +: AW])) begin
          rd_data[i*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
          rd_busy[i]              = busy_d[rd_addr[i*AW +: AW]];
        end
      end
`endif
      if (is_zero_reg(rd_addr[i*AW +: AW])) begin
        rd_data[i*XLEN +: XLEN] = '0;
        rd_busy[i]              = 1'b0;
      end
    end
  end

  assign busy_vec = busy_q;
  assign busy_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb: directed scenarios plus randomized traffic
// compared against an array-based reference model of the register file and scoreboard.
// Build with REGFILE_BYPASS_EN defined to check write-first reads.
module tb_regfile_mp_sb;
  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int NREAD  = 2;
  localparam int NWRITE = 2;
  localparam int AW     = 5;
  localparam int CW     = 6;

  logic                   clk;
  logic                   rst_n;
  logic [NREAD*AW-1:0]    rd_addr;
  logic [NREAD*XLEN-1:0]  rd_data;
  logic [NREAD-1:0]       rd_busy;
  logic [NWRITE-1:0]      wr_en;
  logic [NWRITE*AW-1:0]   wr_addr;
  logic [NWRITE*XLEN-1:0] wr_data;
  logic                   sb_set_en;
  logic [AW-1:0]          sb_set_addr;
  logic                   flush;
  logic [CW-1:0]          busy_cnt;
  logic [NREGS-1:0]       busy_vec;

  int errors = 0;
  int checks = 0;

  // Reference model: plain arrays updated from the architectural rules.
  logic [XLEN-1:0] m_regs [NREGS];
  bit              m_busy [NREGS];

  regfile_mp_sb dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .flush(flush),
    .busy_cnt(busy_cnt), .busy_vec(busy_vec)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int m_cnt();
    int c = 0;
    for (int k = 0; k < NREGS; k++) c += m_busy[k];
    return c;
  endfunction

  function automatic logic [NREGS-1:0] m_vec();
    logic [NREGS-1:0] v = '0;
    for (int k = 0; k < NREGS; k++) v[k] = m_busy[k];
    return v;
  endfunction

  // Expected read data for address a given the inputs currently driven.
  function automatic logic [XLEN-1:0] exp_rd(input int a);
    logic [XLEN-1:0] v;
    if (a == 0) return '0;
    v = m_regs[a];
`ifdef REGFILE_BYPASS_EN
    for (int j = 0; j < NWRITE; j++)
      if (wr_en[j] && int'(wr_addr[j*AW +: AW]) == a) v = wr_data[j*XLEN +: XLEN];
`endif
    return v;
  endfunction

  function automatic logic exp_bz(input int a);
    if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    for (int j = 0; j < NWRITE; j++)
      if (wr_en[j] && int'(wr_addr[j*AW +: AW]) == a)
        return sb_set_en && (int'(sb_set_addr) == a);
`endif
    return m_busy[a];
  endfunction

  task automatic drive(input logic [1:0] we, input int wa0, input logic [XLEN-1:0] wd0,
                       input int wa1, input logic [XLEN-1:0] wd1,
                       input logic se, input int sa, input logic fl,
                       input int ra0, input int ra1);
    wr_en       = we;
    wr_addr     = {AW'(wa1), AW'(wa0)};
    wr_data     = {wd1, wd0};
    sb_set_en   = se;
    sb_set_addr = AW'(sa);
    flush       = fl;
    rd_addr     = {AW'(ra1), AW'(ra0)};
  endtask

  task automatic idle(input int ra0, input int ra1);
    drive(2'b00, 0, '0, 0, '0, 1'b0, 0, 1'b0, ra0, ra1);
  endtask

  // One clock edge; the model applies the same-cycle inputs, then outputs settle.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      for (int k = 0; k < NREGS; k++) begin
        m_regs[k] = '0;
        m_busy[k] = 1'b0;
      end
    end else begin
      for (int j = 0; j < NWRITE; j++)
        if (wr_en[j] && wr_addr[j*AW +: AW] != 0)
          m_regs[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
      if (flush)
        for (int k = 0; k < NREGS; k++) m_busy[k] = 1'b0;
      for (int j = 0; j < NWRITE; j++)
        if (wr_en[j]) m_busy[wr_addr[j*AW +: AW]] = 1'b0;
      if (sb_set_en && sb_set_addr != 0) m_busy[sb_set_addr] = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(0, 1);
    tick();
    rst_n = 1'b1;
    #1;
    for (int p = 0; p < NREAD; p++) begin
      checks++;
      if (rd_data[p*XLEN +: XLEN] !== 32'h0) begin
        errors++; $display("FAIL reset_rd_data port%0d got=%h want=0", p, rd_data[p*XLEN +: XLEN]);
      end
      checks++;
      if (rd_busy[p] !== 1'b0) begin
        errors++; $display("FAIL reset_rd_busy port%0d got=%b want=0", p, rd_busy[p]);
      end
    end
    checks++;
    if (busy_cnt !== 6'd0) begin errors++; $display("FAIL reset_busy_cnt got=%0d want=0", busy_cnt); end
    checks++;
    if (busy_vec !== 32'h0) begin errors++; $display("FAIL reset_busy_vec got=%h want=0", busy_vec); end
  endtask

  task automatic test_write_read();
    drive(2'b01, 5, 32'hDEADBEEF, 0, '0, 1'b0, 0, 1'b0, 0, 0);
    tick();
    idle(0, 5);
    #1;
    checks++;
    if (rd_data[XLEN +: XLEN] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL write_read_x5 got=%h want=deadbeef", rd_data[XLEN +: XLEN]);
    end
    drive(2'b01, 0, 32'h1234, 0, '0, 1'b0, 0, 1'b0, 0, 0);
    tick();
    idle(0, 0);
    #1;
    checks++;
    if (rd_data[0 +: XLEN] !== 32'h0) begin
      errors++; $display("FAIL zero_reg_write got=%h want=0", rd_data[0 +: XLEN]);
    end
  endtask

  task automatic test_write_priority();
    drive(2'b11, 7, 32'h11, 7, 32'h22, 1'b0, 0, 1'b0, 0, 0);
    tick();
    idle(7, 0);
    #1;
    checks++;
    if (rd_data[0 +: XLEN] !== 32'h22) begin
      errors++; $display("FAIL write_priority_x7 got=%h want=22", rd_data[0 +: XLEN]);
    end
  endtask

  task automatic test_scoreboard();
    drive(2'b00, 0, '0, 0, '0, 1'b1, 3, 1'b0, 0, 0);
    tick();
    drive(2'b00, 0, '0, 0, '0, 1'b1, 4, 1'b0, 0, 0);
    tick();
    idle(3, 4);
    #1;
    checks++;
    if (busy_cnt !== 6'd2) begin errors++; $display("FAIL sb_set_cnt got=%0d want=2", busy_cnt); end
    checks++;
    if (rd_busy !== 2'b11) begin errors++; $display("FAIL sb_set_rd_busy got=%b want=11", rd_busy); end
    drive(2'b01, 3, 32'h33, 0, '0, 1'b0, 0, 1'b0, 3, 4);
    tick();
    idle(3, 4);
    #1;
    checks++;
    if (busy_cnt !== 6'd1) begin errors++; $display("FAIL sb_clear_cnt got=%0d want=1", busy_cnt); end
    checks++;
    if (rd_busy[0] !== 1'b0) begin errors++; $display("FAIL sb_clear_x3_busy got=%b want=0", rd_busy[0]); end
    checks++;
    if (rd_data[0 +: XLEN] !== 32'h33) begin
      errors++; $display("FAIL sb_clear_x3_data got=%h want=33", rd_data[0 +: XLEN]);
    end
    drive(2'b01, 4, 32'h44, 0, '0, 1'b1, 4, 1'b0, 4, 0);
    tick();
    idle(4, 0);
    #1;
    checks++;
    if (rd_busy[0] !== 1'b1) begin errors++; $display("FAIL set_beats_clear_busy got=%b want=1", rd_busy[0]); end
    checks++;
    if (rd_data[0 +: XLEN] !== 32'h44) begin
      errors++; $display("FAIL set_beats_clear_data got=%h want=44", rd_data[0 +: XLEN]);
    end
    checks++;
    if (busy_cnt !== 6'd1) begin errors++; $display("FAIL set_beats_clear_cnt got=%0d want=1", busy_cnt); end
  endtask

  task automatic test_flush();
    drive(2'b00, 0, '0, 0, '0, 1'b1, 3, 1'b0, 0, 0);
    tick();
    drive(2'b00, 0, '0, 0, '0, 1'b1, 9, 1'b0, 0, 0);
    tick();
    checks++;
    if (busy_cnt !== 6'd3) begin errors++; $display("FAIL pre_flush_cnt got=%0d want=3", busy_cnt); end
    drive(2'b00, 0, '0, 0, '0, 1'b1, 10, 1'b1, 3, 4);
    tick();
    idle(3, 4);
    #1;
    checks++;
    if (busy_vec !== 32'h0000_0400) begin
      errors++; $display("FAIL flush_set_vec got=%h want=00000400", busy_vec);
    end
    checks++;
    if (busy_cnt !== 6'd1) begin errors++; $display("FAIL flush_set_cnt got=%0d want=1", busy_cnt); end
    checks++;
    if (rd_data !== {32'h44, 32'h33}) begin
      errors++; $display("FAIL flush_keeps_data got=%h want=%h", rd_data, {32'h44, 32'h33});
    end
  endtask

  task automatic test_same_cycle_read();
    logic [XLEN-1:0] want;
    drive(2'b01, 6, 32'h0BADF00D, 0, '0, 1'b0, 0, 1'b0, 0, 0);
    tick();
    drive(2'b01, 6, 32'hA5A5A5A5, 0, '0, 1'b0, 0, 1'b0, 6, 6);
    #1;
`ifdef REGFILE_BYPASS_EN
    want = 32'hA5A5A5A5;
`else
    want = 32'h0BADF00D;
`endif
    checks++;
    if (rd_data[0 +: XLEN] !== want) begin
      errors++; $display("FAIL same_cycle_read got=%h want=%h", rd_data[0 +: XLEN], want);
    end
    tick();
    idle(6, 0);
    #1;
    checks++;
    if (rd_data[0 +: XLEN] !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL after_write_read got=%h want=a5a5a5a5", rd_data[0 +: XLEN]);
    end
  endtask

  task automatic test_mid_reset();
    drive(2'b01, 13, 32'h55, 0, '0, 1'b1, 12, 1'b0, 0, 0);
    tick();
    rst_n = 1'b0;
    drive(2'b11, 13, 32'h99, 14, 32'h77, 1'b1, 15, 1'b1, 13, 14);
    tick();
    rst_n = 1'b1;
    idle(13, 14);
    #1;
    checks++;
    if (rd_data !== 64'h0) begin errors++; $display("FAIL mid_reset_data got=%h want=0", rd_data); end
    checks++;
    if (busy_cnt !== 6'd0) begin errors++; $display("FAIL mid_reset_cnt got=%0d want=0", busy_cnt); end
    checks++;
    if (busy_vec !== 32'h0) begin errors++; $display("FAIL mid_reset_vec got=%h want=0", busy_vec); end
  endtask

  task automatic test_random();
    int hi;
    for (int it = 0; it < 600; it++) begin
      hi = (it % 3 == 0) ? 31 : 7;   // narrow window most of the time to force collisions
      rst_n = ($urandom_range(0, 63) != 0);
      drive(2'($urandom_range(0, 3)),
            $urandom_range(0, hi), $urandom, $urandom_range(0, hi), $urandom,
            1'($urandom_range(0, 1)), $urandom_range(0, hi),
            ($urandom_range(0, 15) == 0),
            $urandom_range(0, hi), $urandom_range(0, hi));
      #1;
      for (int p = 0; p < NREAD; p++) begin
        checks++;
        if (rd_data[p*XLEN +: XLEN] !== exp_rd(int'(rd_addr[p*AW +: AW]))) begin
          errors++;
          $display("FAIL rand_rd_data it=%0d port%0d addr=%0d got=%h want=%h", it, p,
                   rd_addr[p*AW +: AW], rd_data[p*XLEN +: XLEN], exp_rd(int'(rd_addr[p*AW +: AW])));
        end
        checks++;
        if (rd_busy[p] !== exp_bz(int'(rd_addr[p*AW +: AW]))) begin
          errors++;
          $display("FAIL rand_rd_busy it=%0d port%0d addr=%0d got=%b want=%b", it, p,
                   rd_addr[p*AW +: AW], rd_busy[p], exp_bz(int'(rd_addr[p*AW +: AW])));
        end
      end
      tick();
      checks++;
      if (busy_vec !== m_vec()) begin
        errors++; $display("FAIL rand_busy_vec it=%0d got=%h want=%h", it, busy_vec, m_vec());
      end
      checks++;
      if (busy_cnt !== CW'(m_cnt())) begin
        errors++; $display("FAIL rand_busy_cnt it=%0d got=%0d want=%0d", it, busy_cnt, m_cnt());
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle(0, 1);
    for (int k = 0; k < NREGS; k++) begin
      m_regs[k] = '0;
      m_busy[k] = 1'b0;
    end
    test_reset();
    test_write_read();
    test_write_priority();
    test_scoreboard();
    test_flush();
    test_same_cycle_read();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
